// File: rtl/protobuf_field_encoder_pkg.sv
// Shared definitions for the protobuf field encoder: wire-type codes,
// worst-case byte counts, FSM state encoding and the varint length rule.
package protobuf_pkg;

    localparam logic [2:0] WT_VARINT  = 3'd0;
    localparam logic [2:0] WT_FIXED64 = 3'd1;
    localparam logic [2:0] WT_FIXED32 = 3'd5;

    // A 32-bit tag never needs more than 5 varint bytes, a 64-bit value 10.
    localparam int MAX_TAG_BYTES = 5;
    localparam int MAX_VAL_BYTES = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TAG,
        ST_VAL,
        ST_FLUSH
    } enc_state_t;

    // Number of 7-bit groups needed to varint-encode a value; zero still takes one byte.
    function automatic logic [3:0] varint_nbytes(input logic [63:0] value);
        logic [3:0] n;
        n = 4'd1;
        for (int i = 1; i < MAX_VAL_BYTES; i++) begin
            if ((value >> (7 * i)) != 64'd0) begin
                n = 4'(i + 1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/protobuf_field_encoder_packer.sv
// Byte-in / word-out accumulator. Bytes fill lanes from lane 0 upward; a
// full accumulator, or a flush of a partial one, is moved into the output
// register, which is held stable until the downstream accepts it.
module pb_byte_packer #(
    parameter int OUT_BYTES = 4
) (
    input  logic                   clock_clk,
    input  logic                   reset_reset_n,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    input  logic                   byte_last,
    output logic                   byte_ready,
    input  logic                   flush,
    output logic                   acc_empty,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*OUT_BYTES-1:0] out_data,
    output logic [OUT_BYTES-1:0]   out_keep,
    output logic                   out_last
);

    localparam int CW = $clog2(OUT_BYTES + 1);

    logic [8*OUT_BYTES-1:0] acc_data;
    logic [CW-1:0]          acc_cnt;
    logic [8*OUT_BYTES-1:0] wr_data;
    logic [OUT_BYTES-1:0]   keep_mask;
    logic                   out_free;
    logic                   acc_fills;

    // Output slot can take a new word when empty or being handed off this cycle;
    // byte generation stalls whenever it cannot.
    assign out_free   = !out_valid || out_ready;
    assign byte_ready = out_free;
    assign acc_empty  = (acc_cnt == '0);
    assign acc_fills  = (acc_cnt == CW'(OUT_BYTES - 1));

    // Merge the incoming byte into its lane and build the keep mask for a partial flush.
    always_comb begin
        wr_data   = acc_data;
        keep_mask = '0;
        for (int k = 0; k < OUT_BYTES; k++) begin
            if (acc_cnt == CW'(k)) begin
                wr_data[8*k +: 8] = byte_data;
            end
            keep_mask[k] = (CW'(k) < acc_cnt);
        end
    end

    // Accumulate bytes and move completed or flushed words into the output register.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            acc_data  <= '0;
            acc_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (byte_valid && byte_ready) begin
                if (acc_fills) begin
                    out_data  <= wr_data;
                    out_keep  <= '1;
                    out_last  <= byte_last;
                    out_valid <= 1'b1;
                    acc_data  <= '0;
                    acc_cnt   <= '0;
                end else begin
                    acc_data <= wr_data;
                    acc_cnt  <= acc_cnt + CW'(1);
                end
            end else if (flush && !acc_empty && out_free) begin
                out_data  <= acc_data;
                out_keep  <= keep_mask;
                out_last  <= 1'b1;
                out_valid <= 1'b1;
                acc_data  <= '0;
                acc_cnt   <= '0;
            end
        end
    end

endmodule

// File: rtl/protobuf_field_encoder.sv
// Protobuf field encoder: takes one field record per handshake, emits the
// varint tag followed by the varint / fixed32 / fixed64 value, one byte per
// cycle, into a little-endian word packer, and tracks message completion.
module protobuf_field_encoder
    import protobuf_pkg::*;
#(
    parameter int VAL_W     = 64,
    parameter int FIELD_W   = 29,
    parameter int OUT_BYTES = 4
) (
    input  logic                   clock_clk,
    input  logic                   reset_reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FIELD_W-1:0]     in_field,
    input  logic [2:0]             in_wtype,
    input  logic                   in_zigzag,
    input  logic [VAL_W-1:0]       in_value,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*OUT_BYTES-1:0] out_data,
    output logic [OUT_BYTES-1:0]   out_keep,
    output logic                   out_last,
    output logic                   msg_done,
    output logic [15:0]            msg_len,
    output logic                   err_wtype
);

    enc_state_t state, next_state;

    logic [31:0]      tag_sr;
    logic [3:0]       tag_cnt;
    logic [VAL_W-1:0] val_sr;
    logic [3:0]       val_cnt;
    logic             val_is_varint;
    logic             rec_last;

    logic             accept;
    logic             supported;
    logic [31:0]      tag_word;
    logic [3:0]       tag_len;
    logic [VAL_W-1:0] zz_value;
    logic [VAL_W-1:0] enc_value;
    logic [3:0]       val_len;

    logic             byte_valid;
    logic             byte_ready;
    logic             byte_last;
    logic [7:0]       byte_data;
    logic             byte_fire;
    logic             flush_req;
    logic             acc_empty;
    logic             done_now;
    logic [15:0]      byte_cnt;

    assign accept    = in_valid && in_ready;
    assign supported = (in_wtype == WT_VARINT) || (in_wtype == WT_FIXED64) ||
                       (in_wtype == WT_FIXED32);
    assign tag_word  = 32'({in_field, in_wtype});
    assign tag_len   = varint_nbytes(64'(tag_word));
    assign byte_fire = byte_valid && byte_ready;

    // Prepare the value to encode (optionally zigzagged) and its byte count at accept time.
    always_comb begin
        zz_value  = (in_value << 1) ^ {VAL_W{in_value[VAL_W-1]}};
        enc_value = (in_wtype == WT_VARINT && in_zigzag) ? zz_value : in_value;
        val_len   = 4'd0;
        case (in_wtype)
            WT_VARINT:  val_len = varint_nbytes(64'(enc_value));
            WT_FIXED64: val_len = 4'd8;
            WT_FIXED32: val_len = 4'd4;
            default:    val_len = 4'd0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and byte/flush requests towards the packer.
    always_comb begin
        next_state = state;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;
        flush_req  = 1'b0;
        done_now   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (supported) begin
                        next_state = ST_TAG;
                    end else if (in_last) begin
                        next_state = ST_FLUSH;
                    end
                end
            end
            ST_TAG: begin
                byte_valid = 1'b1;
                byte_data  = {tag_cnt != 4'd1, tag_sr[6:0]};
                if (byte_ready && tag_cnt == 4'd1) begin
                    next_state = ST_VAL;
                end
            end
            ST_VAL: begin
                byte_valid = 1'b1;
                byte_data  = val_is_varint ? {val_cnt != 4'd1, val_sr[6:0]} : val_sr[7:0];
                byte_last  = rec_last && (val_cnt == 4'd1);
                if (byte_ready && val_cnt == 4'd1) begin
                    next_state = rec_last ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                flush_req = 1'b1;
                if ((out_valid && out_ready && out_last) || (acc_empty && !out_valid)) begin
                    done_now   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Capture the record on accept, then shift out one tag/value byte per accepted byte.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tag_sr        <= '0;
            tag_cnt       <= '0;
            val_sr        <= '0;
            val_cnt       <= '0;
            val_is_varint <= 1'b0;
            rec_last      <= 1'b0;
        end else if (accept) begin
            tag_sr        <= tag_word;
            tag_cnt       <= tag_len;
            val_sr        <= enc_value;
            val_cnt       <= val_len;
            val_is_varint <= (in_wtype == WT_VARINT);
            rec_last      <= in_last;
        end else if (byte_fire) begin
            if (state == ST_TAG) begin
                tag_sr  <= tag_sr >> 7;
                tag_cnt <= tag_cnt - 4'd1;
            end else begin
                val_sr  <= val_is_varint ? (val_sr >> 7) : (val_sr >> 8);
                val_cnt <= val_cnt - 4'd1;
            end
        end
    end

    // Registered handshake, error and message-completion outputs plus the saturating byte count.
    always_ff @(posedge clock_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            in_ready  <= 1'b0;
            err_wtype <= 1'b0;
            msg_done  <= 1'b0;
            msg_len   <= '0;
            byte_cnt  <= '0;
        end else begin
            in_ready  <= (next_state == ST_IDLE);
            err_wtype <= accept && !supported;
            msg_done  <= done_now;
            if (done_now) begin
                msg_len  <= byte_cnt;
                byte_cnt <= '0;
            end else if (byte_fire && byte_cnt != 16'hFFFF) begin
                byte_cnt <= byte_cnt + 16'd1;
            end
        end
    end

    pb_byte_packer #(
        .OUT_BYTES (OUT_BYTES)
    ) u_packer (
        .clock_clk     (clock_clk),
        .reset_reset_n (reset_reset_n),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_last     (byte_last),
        .byte_ready    (byte_ready),
        .flush         (flush_req),
        .acc_empty     (acc_empty),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_keep      (out_keep),
        .out_last      (out_last)
    );

endmodule

// File: tb/tb_protobuf_field_encoder.sv
// Directed testbench for protobuf_field_encoder with hand-computed wire bytes.
module tb_protobuf_field_encoder;

    localparam int VAL_W     = 64;
    localparam int FIELD_W   = 29;
    localparam int OUT_BYTES = 4;

    logic               clock_clk;
    logic               reset_reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [FIELD_W-1:0] in_field;
    logic [2:0]         in_wtype;
    logic               in_zigzag;
    logic [VAL_W-1:0]   in_value;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [3:0]         out_keep;
    logic               out_last;
    logic               msg_done;
    logic [15:0]        msg_len;
    logic               err_wtype;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int wbase, lbase, ebase;

    logic [31:0] data_q[$];
    logic [3:0]  keep_q[$];
    logic        last_q[$];
    logic [15:0] len_q[$];

    protobuf_field_encoder #(
        .VAL_W     (VAL_W),
        .FIELD_W   (FIELD_W),
        .OUT_BYTES (OUT_BYTES)
    ) dut (
        .clock_clk     (clock_clk),
        .reset_reset_n (reset_reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_field      (in_field),
        .in_wtype      (in_wtype),
        .in_zigzag     (in_zigzag),
        .in_value      (in_value),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_keep      (out_keep),
        .out_last      (out_last),
        .msg_done      (msg_done),
        .msg_len       (msg_len),
        .err_wtype     (err_wtype)
    );

    initial clock_clk = 1'b0;
    always #5 clock_clk = ~clock_clk;

    // Log every accepted output word, completed message length and error pulse.
    always @(negedge clock_clk) begin
        if (out_valid && out_ready) begin
            data_q.push_back(out_data);
            keep_q.push_back(out_keep);
            last_q.push_back(out_last);
        end
        if (msg_done) len_q.push_back(msg_len);
        if (err_wtype) err_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic markLog();
        wbase = data_q.size();
        lbase = len_q.size();
        ebase = err_cnt;
    endtask

    task automatic applyStimulus(input logic [FIELD_W-1:0] field, input logic [2:0] wtype,
                                 input logic zz, input logic [63:0] value, input logic last);
        int n;
        n = 0;
        in_field  = field;
        in_wtype  = wtype;
        in_zigzag = zz;
        in_value  = value;
        in_last   = last;
        in_valid  = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clock_clk);
            n++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clock_clk);
            #1;
            in_valid = 1'b0;
            @(negedge clock_clk);
        end
    endtask

    task automatic waitMsgDone();
        int c;
        c = 0;
        while (len_q.size() <= lbase && c < 1000) begin
            @(negedge clock_clk);
            c++;
        end
        if (len_q.size() <= lbase) checkOutput("msg_done_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clock_clk);
    endtask

    task automatic checkWord(input string name, input int idx, input logic [31:0] d,
                             input logic [3:0] k, input logic l);
        if (wbase + idx < data_q.size()) begin
            checkOutput({name, "_data"}, 64'(data_q[wbase + idx]), 64'(d));
            checkOutput({name, "_keep"}, 64'(keep_q[wbase + idx]), 64'(k));
            checkOutput({name, "_last"}, 64'(last_q[wbase + idx]), 64'(l));
        end else begin
            checkOutput({name, "_missing"}, 64'(data_q.size() - wbase), 64'(idx + 1));
        end
    endtask

    task automatic checkMsg(input string name, input int nwords, input logic [15:0] len);
        checkOutput({name, "_nwords"}, 64'(data_q.size() - wbase), 64'(nwords));
        if (len_q.size() > lbase) checkOutput({name, "_len"}, 64'(len_q[lbase]), 64'(len));
        else checkOutput({name, "_len_missing"}, 64'd0, 64'd1);
    endtask

    task automatic checkMaxWords(input string name);
        checkWord({name, "_w0"}, 0, 32'hFFFFFFF8, 4'b1111, 1'b0);
        checkWord({name, "_w1"}, 1, 32'hFFFFFF0F, 4'b1111, 1'b0);
        checkWord({name, "_w2"}, 2, 32'hFFFFFFFF, 4'b1111, 1'b0);
        checkWord({name, "_w3"}, 3, 32'h0001FFFF, 4'b0111, 1'b1);
        checkMsg(name, 4, 16'd15);
    endtask

    function automatic logic [63:0] outSnapshot();
        return 64'({in_ready, out_valid, out_last, msg_done, err_wtype, out_keep, out_data, msg_len});
    endfunction

    initial begin
        int n;
        reset_reset_n = 1'b0;
        in_valid  = 1'b0;
        in_field  = '0;
        in_wtype  = '0;
        in_zigzag = 1'b0;
        in_value  = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge clock_clk);
        checkOutput("rst_outputs", outSnapshot(), 64'd0);
        reset_reset_n = 1'b1;
        #1;
        checkOutput("rst_release_ready", 64'(in_ready), 64'd0);
        @(negedge clock_clk);
        checkOutput("in_ready_rise", 64'(in_ready), 64'd1);

        // basic varint: 08 96 01
        markLog();
        applyStimulus(29'd1, 3'd0, 1'b0, 64'd150, 1'b1);
        waitMsgDone();
        checkWord("basic", 0, 32'h00019608, 4'b0111, 1'b1);
        checkMsg("basic", 1, 16'd3);

        // zigzag -1 then 1: 10 01 10 02
        markLog();
        applyStimulus(29'd2, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        applyStimulus(29'd2, 3'd0, 1'b1, 64'd1, 1'b1);
        waitMsgDone();
        checkWord("zigzag", 0, 32'h02100110, 4'b1111, 1'b1);
        checkMsg("zigzag", 1, 16'd4);

        // fixed32: 2D EF BE AD DE
        markLog();
        applyStimulus(29'd5, 3'd5, 1'b0, 64'h0000_0000_DEAD_BEEF, 1'b1);
        waitMsgDone();
        checkWord("fx32_w0", 0, 32'hADBEEF2D, 4'b1111, 1'b0);
        checkWord("fx32_w1", 1, 32'h000000DE, 4'b0001, 1'b1);
        checkMsg("fx32", 2, 16'd5);

        // fixed64: 19 08 07 06 05 04 03 02 01
        markLog();
        applyStimulus(29'd3, 3'd1, 1'b0, 64'h0102_0304_0506_0708, 1'b1);
        waitMsgDone();
        checkWord("fx64_w0", 0, 32'h06070819, 4'b1111, 1'b0);
        checkWord("fx64_w1", 1, 32'h02030405, 4'b1111, 1'b0);
        checkWord("fx64_w2", 2, 32'h00000001, 4'b0001, 1'b1);
        checkMsg("fx64", 3, 16'd9);

        // maximum field and value widths
        markLog();
        applyStimulus(29'h1FFF_FFFF, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        waitMsgDone();
        checkMaxWords("max");

        // same record with a 10-cycle stall on the first word
        markLog();
        applyStimulus(29'h1FFF_FFFF, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clock_clk);
            n++;
        end
        checkOutput("bp_valid_seen", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_clk);
            checkOutput("bp_data", 64'(out_data), 64'hFFFFFFF8);
            checkOutput("bp_ctrl", 64'({out_valid, out_keep, out_last, in_ready}), 64'b1111100);
        end
        out_ready = 1'b1;
        waitMsgDone();
        checkMaxWords("bp");

        // unsupported wire type ending an empty message
        markLog();
        applyStimulus(29'd4, 3'd2, 1'b0, 64'd5, 1'b1);
        waitMsgDone();
        checkOutput("err_pulses", 64'(err_cnt - ebase), 64'd1);
        checkMsg("unsup", 0, 16'd0);

        // reset in the middle of a message, then a clean message
        applyStimulus(29'h1FFF_FFFF, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        repeat (3) @(negedge clock_clk);
        reset_reset_n = 1'b0;
        #1;
        checkOutput("midrst_outputs", outSnapshot(), 64'd0);
        repeat (2) @(negedge clock_clk);
        reset_reset_n = 1'b1;
        @(negedge clock_clk);
        markLog();
        applyStimulus(29'd1, 3'd0, 1'b0, 64'd150, 1'b1);
        waitMsgDone();
        checkWord("post_rst", 0, 32'h00019608, 4'b0111, 1'b1);
        checkMsg("post_rst", 1, 16'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
